fp_norm_unit: RTL and testbench
===============================

Name: fp_norm_unit

Overview:
- Normalization stage directly downstream of SUM_unit in the FP32 add/sub datapath.
- Consumes the 28-bit mantissa sum, its carry-out and the pre-normalization exponent.
- Produces a 27-bit normalized mantissa (hidden + 23 fraction + G/R/S) with the adjusted exponent, plus zero and overflow flags.
- Two-stage pipeline with valid/ready handshake on both sides, so it can sit between a registered SUM stage and the rounding stage.

Parameters:
- SIZE_DATA, 28: width of i_sum. Hidden-bit position is SIZE_DATA-2 (bit 26).
- SIZE_EXP, 8: exponent width.
- SIZE_MANT, 27: output mantissa width (hidden + fraction + GRS).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream data valid
- o_ready  out  1  block can accept input this cycle
- i_sum  in  SIZE_DATA  mantissa sum from SUM_unit
- i_carry  in  1  carry-out from SUM_unit
- i_eff_sub  in  1  1 = effective subtraction (carry ignored)
- i_exp  in  SIZE_EXP  larger operand's biased exponent
- o_valid  out  1  output valid
- i_ready  in  1  downstream accepts output
- o_mant  out  SIZE_MANT  normalized mantissa, bit 26 = hidden bit
- o_exp  out  SIZE_EXP  adjusted exponent
- o_zero  out  1  result is exactly zero
- o_overflow  out  1  exponent saturated to all-ones

Behaviour:
- One clock; reset is asynchronous and active-low. While i_rst_n=0:
  - all pipeline valids clear;
  - o_valid=0, o_mant=0, o_exp=0, o_zero=0, o_overflow=0;
  - o_ready=1 once reset is held, because the pipeline is empty.
- Reset mid-operation discards in-flight data. No output appears for it after release.
- Handshake:
  - Input transfer when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - Stage 2 holds its contents while o_valid && !i_ready.
  - Stage 1 advances when stage 2 is empty or transferring.
  - o_ready = !s1_valid || s1_advance (combinational).
  - Latency is 2 cycles from input transfer to o_valid. Throughput is 1/cycle with no stalls.
  - Outputs are stable while o_valid && !i_ready.
- Stage 1 (registered):
  - V = i_eff_sub ? {1'b0,i_sum} : {i_carry,i_sum}, 29 bits.
  - lzc = leading zeros of V[26:0], range 0..27 (27 when V[26:0]==0).
  - Register V, lzc, i_exp.
- Stage 2 (registered outputs):
  - V==0 -> o_zero=1, o_mant=0, o_exp=0.
  - V[28]=1 -> mant = V>>2, with bit 0 = V[2]|V[1]|V[0] (sticky fold); exp = i_exp+2.
  - else V[27]=1 -> mant = V>>1, bit 0 = V[1]|V[0]; exp = i_exp+1.
  - else (leading one at or below bit 26):
    - If i_exp > lzc: shift left by lzc; exp = i_exp-lzc.
    - Else denormal: shift left by (i_exp==0 ? 0 : i_exp-1); exp = 0.
  - Exponent arithmetic uses SIZE_EXP+2 bits.
  - Result exp >= 2^SIZE_EXP-1 -> o_overflow=1, o_exp=all-ones, o_mant=0.
  - o_zero and o_overflow are mutually exclusive.

Decomposition:
- Package fp_norm_pkg holds:
  - SIZE_DATA, SIZE_EXP, SIZE_MANT;
  - HIDDEN_POS=26, EXP_MAX=255;
  - a struct for the stage-1 register (V, lzc, exp).
- Sub-module fp_lzc: parameterized leading-zero counter (priority tree), purely combinational, instantiated in stage 1.

Test Plan:
- Add carry into bit 27:
  - Stimulus: i_sum=0x8000000, i_carry=0, i_eff_sub=0, i_exp=127.
  - Required: after 2 cycles, o_mant=0x4000000, o_exp=128, flags 0.
- Carry-out plus sticky:
  - Stimulus: i_sum=0x0000001, i_carry=1, i_eff_sub=0, i_exp=100.
  - Required: o_mant=0x4000001, o_exp=102.
- Cancellation:
  - Stimulus: i_sum=0x0000008, i_eff_sub=1, i_exp=127.
  - Required: o_mant=0x4000000, o_exp=104.
  - Same input with i_exp=10 -> o_mant=0x0001000, o_exp=0.
- Zero and overflow:
  - i_sum=0, i_eff_sub=1, i_exp=90 -> o_zero=1, o_mant=0, o_exp=0.
  - i_sum=0x8000000, i_eff_sub=0, i_exp=254 -> o_overflow=1, o_exp=255, o_mant=0.
- Backpressure:
  - Stimulus: stream 4 back-to-back inputs with i_ready=0 for cycles 2-5.
  - Required: o_ready drops once both stages are full; no input is lost or duplicated; outputs stay stable while stalled; results emerge in order.
- Async reset:
  - Stimulus: assert i_rst_n=0 mid-stream, between clock edges.
  - Required: o_valid=0 immediately; after release, no stale output appears.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// ============================================================================
// Module   : fp_norm_pkg
// Brief    : Shared widths and stage-1 record for the FP32 normalization stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fp_norm_pkg;

    localparam int SIZE_DATA  = 28;
    localparam int SIZE_EXP   = 8;
    localparam int SIZE_MANT  = 27;
    localparam int HIDDEN_POS = 26;
    localparam int EXP_MAX    = 255;
    localparam int LZC_W      = $clog2(SIZE_MANT + 1);
    localparam int EXP_W      = SIZE_EXP + 2;

    typedef struct packed {
        logic [SIZE_DATA:0]   v;
        logic [LZC_W-1:0]     lzc;
        logic [SIZE_EXP-1:0]  exp;
    } s1_reg_t;

endpackage

`default_nettype wire

// File: rtl/fp_norm_unit_lzc.sv
// ============================================================================
// Module   : fp_lzc
// Brief    : Combinational leading-zero counter; all-zero input yields WIDTH.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_lzc #(
    parameter int WIDTH = 27,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count
);

    // Ascending scan: the highest set bit is the last to write, so it wins priority.
    always_comb begin
        o_count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_norm_unit.sv
// ============================================================================
// Module   : fp_norm_unit
// Brief    : Two-stage normalization of the FP32 add/sub mantissa sum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_norm_unit
    import fp_norm_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_sum,
    input  logic                 i_carry,
    input  logic                 i_eff_sub,
    input  logic [SIZE_EXP-1:0]  i_exp,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_MANT-1:0] o_mant,
    output logic [SIZE_EXP-1:0]  o_exp,
    output logic                 o_zero,
    output logic                 o_overflow
);

    logic                 r_s1_valid;
    s1_reg_t              r_s1;
    logic                 w_s2_adv;
    logic [SIZE_DATA:0]   w_v;
    logic [LZC_W-1:0]     w_lzc;
    logic [EXP_W-1:0]     w_e_ext;
    logic [EXP_W-1:0]     w_lzc_ext;
    logic [EXP_W-1:0]     w_exp_raw;
    logic [SIZE_EXP-1:0]  w_exp_fin;
    logic [SIZE_MANT-1:0] w_mant;
    logic [LZC_W-1:0]     w_shamt;
    logic                 w_zero;
    logic                 w_ovf;

    // Carry-out is meaningless on effective subtraction.
    assign w_v = i_eff_sub ? {1'b0, i_sum} : {i_carry, i_sum};

    fp_lzc #(.WIDTH(SIZE_MANT), .CW(LZC_W)) u_lzc (
        .i_data  (w_v[HIDDEN_POS:0]),
        .o_count (w_lzc)
    );

    assign w_s2_adv = !o_valid || i_ready;
    assign o_ready  = !r_s1_valid || w_s2_adv;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (o_ready) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1 <= '{v: w_v, lzc: w_lzc, exp: i_exp};
            end
        end
    end

    assign w_e_ext   = EXP_W'(r_s1.exp);
    assign w_lzc_ext = EXP_W'(r_s1.lzc);

    always_comb begin
        w_mant    = '0;
        w_exp_raw = '0;
        w_shamt   = '0;
        w_zero    = 1'b0;
        w_ovf     = 1'b0;
        if (r_s1.v == '0) begin
            w_zero = 1'b1;
        end else if (r_s1.v[SIZE_DATA]) begin
            w_mant    = {r_s1.v[SIZE_DATA:3], |r_s1.v[2:0]};
            w_exp_raw = w_e_ext + EXP_W'(2);
        end else if (r_s1.v[SIZE_DATA-1]) begin
            w_mant    = {r_s1.v[SIZE_DATA-1:2], |r_s1.v[1:0]};
            w_exp_raw = w_e_ext + EXP_W'(1);
        end else if (w_e_ext > w_lzc_ext) begin
            w_mant    = r_s1.v[HIDDEN_POS:0] << r_s1.lzc;
            w_exp_raw = w_e_ext - w_lzc_ext;
        end else begin
            // Exponent cannot absorb the full shift: produce a denormal at exp 0.
            w_shamt   = (r_s1.exp == '0) ? '0 : LZC_W'(r_s1.exp - 1'b1);
            w_mant    = r_s1.v[HIDDEN_POS:0] << w_shamt;
            w_exp_raw = '0;
        end
        if (w_exp_raw >= EXP_W'(EXP_MAX)) begin
            w_ovf  = 1'b1;
            w_mant = '0;
        end
    end

    assign w_exp_fin = w_ovf ? SIZE_EXP'(EXP_MAX) : w_exp_raw[SIZE_EXP-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_mant     <= '0;
            o_exp      <= '0;
            o_zero     <= 1'b0;
            o_overflow <= 1'b0;
        end else if (w_s2_adv) begin
            o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_mant     <= w_mant;
                o_exp      <= w_exp_fin;
                o_zero     <= w_zero;
                o_overflow <= w_ovf;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_unit.sv
// ============================================================================
// Module   : tb_fp_norm_unit
// Brief    : Self-checking bench for fp_norm_unit against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_norm_unit;
    import fp_norm_pkg::*;

    typedef struct packed {
        logic [SIZE_MANT-1:0] mant;
        logic [SIZE_EXP-1:0]  exp;
        logic                 zero;
        logic                 ovf;
    } res_t;

    typedef struct packed {
        logic [SIZE_DATA-1:0] sum;
        logic                 carry;
        logic                 eff;
        logic [SIZE_EXP-1:0]  exp;
    } in_t;

    typedef struct packed {
        in_t  in;
        res_t out;
    } dvec_t;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_valid = 1'b0;
    logic                 i_ready = 1'b1;
    logic [SIZE_DATA-1:0] i_sum = '0;
    logic                 i_carry = 1'b0;
    logic                 i_eff_sub = 1'b0;
    logic [SIZE_EXP-1:0]  i_exp = '0;
    logic                 o_ready;
    logic                 o_valid;
    logic [SIZE_MANT-1:0] o_mant;
    logic [SIZE_EXP-1:0]  o_exp;
    logic                 o_zero;
    logic                 o_overflow;

    int   n_vec  = 0;
    int   n_fail = 0;
    res_t sb[$];

    dvec_t dir_tab [12] = '{
        {28'h8000000, 1'b0, 1'b0, 8'd127, 27'h4000000, 8'd128, 1'b0, 1'b0},
        {28'h0000001, 1'b1, 1'b0, 8'd100, 27'h4000001, 8'd102, 1'b0, 1'b0},
        {28'h0000008, 1'b0, 1'b1, 8'd127, 27'h4000000, 8'd104, 1'b0, 1'b0},
        {28'h0000008, 1'b0, 1'b1, 8'd10,  27'h0001000, 8'd0,   1'b0, 1'b0},
        {28'h0000000, 1'b0, 1'b1, 8'd90,  27'h0000000, 8'd0,   1'b1, 1'b0},
        {28'h8000000, 1'b0, 1'b0, 8'd254, 27'h0000000, 8'd255, 1'b0, 1'b1},
        {28'h0000008, 1'b0, 1'b1, 8'd0,   27'h0000008, 8'd0,   1'b0, 1'b0},
        {28'h8000000, 1'b1, 1'b1, 8'd127, 27'h4000000, 8'd128, 1'b0, 1'b0},
        {28'h4000000, 1'b0, 1'b1, 8'd255, 27'h0000000, 8'd255, 1'b0, 1'b1},
        {28'h0000008, 1'b0, 1'b1, 8'd23,  27'h2000000, 8'd0,   1'b0, 1'b0},
        {28'h0000008, 1'b0, 1'b1, 8'd24,  27'h4000000, 8'd1,   1'b0, 1'b0},
        {28'h0000000, 1'b1, 1'b0, 8'd5,   27'h4000000, 8'd7,   1'b0, 1'b0}
    };

    fp_norm_unit dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_sum      (i_sum),
        .i_carry    (i_carry),
        .i_eff_sub  (i_eff_sub),
        .i_exp      (i_exp),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_mant     (o_mant),
        .o_exp      (o_exp),
        .o_zero     (o_zero),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Value-level model: locate the leading one, scale to bit 26, adjust exponent.
    function automatic res_t model(input in_t x);
        longint v, m;
        int     p, d, lz, sh, e, en;
        res_t   r;
        r  = '0;
        e  = int'(x.exp);
        m  = 0;
        en = 0;
        v  = longint'(x.sum);
        if (!x.eff && x.carry) v = v + (longint'(1) << 28);
        if (v == 0) begin
            r.zero = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < 29; i++) if (((v >> i) & 1) != 0) p = i;
        if (p > 26) begin
            d  = p - 26;
            m  = v >> d;
            if ((v & ((longint'(1) << d) - 1)) != 0) m = m | 1;
            en = e + d;
        end else begin
            lz = 26 - p;
            if (e > lz) begin
                m  = v << lz;
                en = e - lz;
            end else begin
                sh = (e == 0) ? 0 : e - 1;
                m  = v << sh;
                en = 0;
            end
        end
        if (en >= 255) begin
            r.ovf = 1'b1;
            r.exp = 8'hFF;
        end else begin
            r.mant = m[26:0];
            r.exp  = en[7:0];
        end
        return r;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x.sum   = SIZE_DATA'($urandom());
        x.sum   = x.sum >> $urandom_range(0, 28);
        x.carry = 1'($urandom_range(0, 1));
        x.eff   = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
            0:       x.exp = 8'd0;
            1:       x.exp = 8'd1;
            2:       x.exp = 8'd254;
            3:       x.exp = 8'd255;
            default: x.exp = 8'($urandom_range(0, 255));
        endcase
        return x;
    endfunction

    task automatic drive(input in_t x);
        i_sum     = x.sum;
        i_carry   = x.carry;
        i_eff_sub = x.eff;
        i_exp     = x.exp;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_vec++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        n_vec++; if (o_mant !== '0) begin n_fail++; $display("FAIL reset_mant: got %h want 0", o_mant); end
        n_vec++; if (o_exp !== '0) begin n_fail++; $display("FAIL reset_exp: got %h want 0", o_exp); end
        n_vec++; if (o_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b want 0", o_zero); end
        n_vec++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", o_overflow); end
        i_rst_n = 1'b1;
    endtask

    task automatic test_directed();
        i_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge i_clk); #1;
            drive(dir_tab[k].in);
            i_valid = 1'b1;
            @(posedge i_clk); #1;
            i_valid = 1'b0;
            @(negedge i_clk);
            n_vec++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early: o_valid got %b want 0", k, o_valid); end
            @(negedge i_clk);
            n_vec++;
            if (o_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %b want 1", k, o_valid); end
            n_vec++;
            if ({o_mant, o_exp, o_zero, o_overflow} !== dir_tab[k].out)
                begin n_fail++; $display("FAIL dir%0d_data: got mant=%h exp=%0d z=%b o=%b want %h/%0d/%b/%b", k,
                    o_mant, o_exp, o_zero, o_overflow, dir_tab[k].out.mant, dir_tab[k].out.exp,
                    dir_tab[k].out.zero, dir_tab[k].out.ovf); end
        end
    endtask

    task automatic test_backpressure();
        in_t  v [4];
        res_t held, r;
        int   idx = 0, got = 0, c = 0;
        bit   seen_block = 0, stalled = 0;
        for (int k = 0; k < 4; k++) v[k] = rand_in();
        sb.delete();
        @(posedge i_clk); #1;
        drive(v[0]);
        i_valid = 1'b1;
        i_ready = 1'b1;
        while (c < 40 && got < 4) begin
            @(negedge i_clk);
            if (stalled) begin
                n_vec++;
                if ({o_valid, o_mant, o_exp, o_zero, o_overflow} !== {1'b1, held})
                    begin n_fail++; $display("FAIL bp_stable: got %h want %h", {o_mant, o_exp, o_zero, o_overflow}, held); end
            end
            if (o_valid && i_ready) begin
                n_vec++; got++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL bp_extra: got unexpected output %h", o_mant); end
                else begin
                    r = sb.pop_front();
                    if ({o_mant, o_exp, o_zero, o_overflow} !== r)
                        begin n_fail++; $display("FAIL bp_data: got %h want %h", {o_mant, o_exp, o_zero, o_overflow}, r); end
                end
            end
            if (i_valid && !o_ready) seen_block = 1'b1;
            if (i_valid && o_ready) begin sb.push_back(model(v[idx])); idx++; end
            stalled = o_valid && !i_ready;
            held    = {o_mant, o_exp, o_zero, o_overflow};
            @(posedge i_clk); #1;
            c++;
            i_ready = !(c >= 2 && c <= 5);
            i_valid = (idx < 4);
            if (idx < 4) drive(v[idx]);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        n_vec++; if (got != 4) begin n_fail++; $display("FAIL bp_count: got %0d outputs want 4", got); end
        n_vec++; if (!seen_block) begin n_fail++; $display("FAIL bp_ready_drop: got 0 want 1"); end
        n_vec++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_lost: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_random();
        in_t  cur;
        res_t held, r;
        bit   stalled = 0, acc = 0;
        sb.delete();
        cur = rand_in();
        @(posedge i_clk); #1;
        for (int c = 0; c < 420; c++) begin
            @(negedge i_clk);
            if (stalled) begin
                n_vec++;
                if ({o_valid, o_mant, o_exp, o_zero, o_overflow} !== {1'b1, held})
                    begin n_fail++; $display("FAIL rnd_stable: got %h want %h", {o_mant, o_exp, o_zero, o_overflow}, held); end
            end
            if (o_valid && i_ready) begin
                n_vec++;
                if (sb.size() == 0) begin n_fail++; $display("FAIL rnd_extra: got unexpected output %h", o_mant); end
                else begin
                    r = sb.pop_front();
                    if ({o_mant, o_exp, o_zero, o_overflow} !== r)
                        begin n_fail++; $display("FAIL rnd_data: got %h want %h", {o_mant, o_exp, o_zero, o_overflow}, r); end
                end
            end
            acc = i_valid && o_ready;
            if (acc) sb.push_back(model(cur));
            stalled = o_valid && !i_ready;
            held    = {o_mant, o_exp, o_zero, o_overflow};
            @(posedge i_clk); #1;
            if (c >= 400) begin
                i_valid = 1'b0;
                i_ready = 1'b1;
            end else begin
                if (!(i_valid && !acc)) begin
                    cur     = rand_in();
                    i_valid = ($urandom_range(0, 9) < 7);
                    drive(cur);
                end
                i_ready = ($urandom_range(0, 3) != 0);
            end
        end
        n_vec++; if (sb.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        bit leaked = 0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            drive(rand_in());
            i_valid = 1'b1;
        end
        @(posedge i_clk); #3;
        n_vec++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ar_prefill: o_valid got %b want 1", o_valid); end
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        #1;
        n_vec++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", o_valid); end
        n_vec++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL ar_ready: got %b want 1", o_ready); end
        n_vec++; if (o_mant !== '0) begin n_fail++; $display("FAIL ar_mant: got %h want 0", o_mant); end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            if (o_valid !== 1'b0) leaked = 1'b1;
        end
        n_vec++; if (leaked) begin n_fail++; $display("FAIL ar_stale: got o_valid=1 after release want 0"); end
        @(posedge i_clk); #1;
        drive(dir_tab[1].in);
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        n_vec++;
        if ({o_valid, o_mant, o_exp, o_zero, o_overflow} !== {1'b1, dir_tab[1].out})
            begin n_fail++; $display("FAIL ar_resume: got v=%b %h want %h", o_valid,
                {o_mant, o_exp, o_zero, o_overflow}, dir_tab[1].out); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
